segment_sequencer: RTL

- Parametrised successor to the fixed two-segment modulation/STM timing registers: generalises to NUM_SEGMENTS segments, each with its own cycle length, frequency divider and repetition count.
- Generates the sample index and the active segment, and schedules segment swaps so they land only on loop boundaries.
- Adds finite-repetition stop, which the fixed-register generation lacks.
- Sits between the controller register bank (the per-segment cycle/div/rep registers and the REQ_RD_SEGMENT register) and the modulation or STM memory read path.

---
 rtl/segment_sequencer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/segment_sequencer.sv
// Multi-segment sample sequencer: generates the sample index and active segment,
// defers segment swaps to loop boundaries and stops after a finite repetition count.
module segment_sequencer #(
    parameter int NUM_SEGMENTS = 2,
    parameter int CYCLE_WIDTH  = 15,
    parameter int DIV_WIDTH    = 32,
    parameter int REP_WIDTH    = 16,
    parameter int SEG_WIDTH    = $clog2(NUM_SEGMENTS)
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic                              TICK,
    input  logic                              UPDATE,
    input  logic [SEG_WIDTH-1:0]              REQ_SEGMENT,
    input  logic [NUM_SEGMENTS*CYCLE_WIDTH-1:0] CYCLE,
    input  logic [NUM_SEGMENTS*DIV_WIDTH-1:0] FREQ_DIV,
    input  logic [NUM_SEGMENTS*REP_WIDTH-1:0] REP,
    output logic [CYCLE_WIDTH-1:0]            IDX,
    output logic [SEG_WIDTH-1:0]              SEGMENT,
    output logic                              IDX_VALID,
    output logic                              STOP,
    output logic                              BUSY,
    output logic                              ERR
);

    typedef enum logic [1:0] {IDLE, RUN, PEND, FINISH} state_t;

    localparam logic [SEG_WIDTH:0] SEG_LIMIT = (SEG_WIDTH + 1)'(NUM_SEGMENTS);

    state_t                 state;
    logic [DIV_WIDTH-1:0]   div_cnt;
    logic [REP_WIDTH-1:0]   loop_cnt;
    logic [SEG_WIDTH-1:0]   pend_seg;

    logic [CYCLE_WIDTH-1:0] cur_cycle;
    logic [DIV_WIDTH-1:0]   cur_div;
    logic [REP_WIDTH-1:0]   cur_rep;
    logic [DIV_WIDTH-1:0]   div_last;
    logic                   req_valid;
    logic                   take_req;
    logic                   advance;
    logic                   at_wrap;
    logic                   finish_hit;
    logic                   swap_armed;
    logic [SEG_WIDTH-1:0]   swap_target;

    // Live view of the active segment's configuration fields.
    always_comb begin
        cur_cycle = '0;
        cur_div   = '0;
        cur_rep   = '0;
        for (int s = 0; s < NUM_SEGMENTS; s++) begin
            if (SEGMENT == SEG_WIDTH'(s)) begin
                cur_cycle = CYCLE[s*CYCLE_WIDTH +: CYCLE_WIDTH];
                cur_div   = FREQ_DIV[s*DIV_WIDTH +: DIV_WIDTH];
                cur_rep   = REP[s*REP_WIDTH +: REP_WIDTH];
            end
        end
    end

    // A divider of zero is treated as one, so the terminal count is then zero.
    always_comb begin
        div_last    = (cur_div == '0) ? '0 : cur_div - DIV_WIDTH'(1);
        req_valid   = ({1'b0, REQ_SEGMENT} < SEG_LIMIT);
        take_req    = UPDATE && req_valid;
        advance     = TICK && (div_cnt == div_last);
        at_wrap     = (IDX >= cur_cycle);
        finish_hit  = (cur_rep != '1) && (loop_cnt == cur_rep);
        swap_armed  = (state == PEND) || take_req;
        swap_target = take_req ? REQ_SEGMENT : pend_seg;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            IDX       <= '0;
            SEGMENT   <= '0;
            IDX_VALID <= 1'b0;
            STOP      <= 1'b0;
            BUSY      <= 1'b0;
            ERR       <= 1'b0;
            div_cnt   <= '0;
            loop_cnt  <= '0;
            pend_seg  <= '0;
        end else begin
            IDX_VALID <= 1'b0;
            ERR       <= UPDATE && !req_valid;
            case (state)
                IDLE: begin
                    if (take_req) begin
                        SEGMENT   <= REQ_SEGMENT;
                        IDX       <= '0;
                        IDX_VALID <= 1'b1;
                        div_cnt   <= '0;
                        loop_cnt  <= '0;
                        state     <= RUN;
                    end
                end
                RUN, PEND: begin
                    if (TICK) begin
                        if (advance) begin
                            div_cnt   <= '0;
                            IDX_VALID <= 1'b1;
                            if (at_wrap) begin
                                // A pending swap wins over a finite-repetition stop.
                                if (swap_armed) begin
                                    SEGMENT  <= swap_target;
                                    IDX      <= '0;
                                    loop_cnt <= '0;
                                    BUSY     <= 1'b0;
                                    state    <= RUN;
                                end else if (finish_hit) begin
                                    IDX       <= cur_cycle;
                                    IDX_VALID <= (IDX != cur_cycle);
                                    STOP      <= 1'b1;
                                    state     <= FINISH;
                                end else begin
                                    IDX <= '0;
                                    if (loop_cnt != '1) begin
                                        loop_cnt <= loop_cnt + REP_WIDTH'(1);
                                    end
                                end
                            end else begin
                                IDX <= IDX + CYCLE_WIDTH'(1);
                            end
                        end else begin
                            div_cnt <= div_cnt + DIV_WIDTH'(1);
                        end
                    end
                    if (take_req && !(advance && at_wrap)) begin
                        pend_seg <= REQ_SEGMENT;
                        BUSY     <= 1'b1;
                        state    <= PEND;
                    end
                end
                FINISH: begin
                    if (take_req) begin
                        SEGMENT   <= REQ_SEGMENT;
                        IDX       <= '0;
                        IDX_VALID <= 1'b1;
                        div_cnt   <= '0;
                        loop_cnt  <= '0;
                        STOP      <= 1'b0;
                        state     <= RUN;
                    end else if (IDX != cur_cycle) begin
                        // The held index follows a live change of the cycle length.
                        IDX       <= cur_cycle;
                        IDX_VALID <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
